program_sequencer: RTL and testbench
====================================

# program_sequencer

Feeds the 9-bit processor from a synchronous instruction ROM: fetches each word, drives `din`/`run` to the processor's control unit, waits for `done`, and advances the program counter. It owns the processor's `run` and `din` inputs and sits between the host controls (start/stop/step) and the processor core. It decodes two-word immediate loads (mvi) and includes a watchdog for a missing `done`.

## Interface
- `ADDR_W`, default 5: ROM address width; the program holds up to 2^ADDR_W words.
- `DATA_W`, default 9: instruction width, matching the processor's `ir`.
- `WD_LIMIT`, default 4: number of EXEC cycles without `done` before an error.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle pulse; honoured in IDLE, HALT or ERR.
- `stop`  in  1  level; finishes the current instruction, then goes to IDLE.
- `step_mode`  in  1  1 = pause after every instruction.
- `step`  in  1  one-cycle pulse; releases PAUSE.
- `prog_len`  in  ADDR_W+1  number of valid words, sampled at start.
- `mem_addr`  out  ADDR_W  ROM address.
- `mem_data`  in  DATA_W  ROM data, valid one cycle after `mem_addr`.
- `din`  out  DATA_W  processor data input.
- `run`  out  1  processor run.
- `done`  in  1  processor done (combinational from the control unit).
- `pc`  out  ADDR_W  address of the current instruction.
- `instr_count`  out  8  retired instructions; saturates at 255.
- `busy`  out  1  state is not IDLE, HALT or ERR.
- `halted`  out  1  state == HALT.
- `err`  out  1  state == ERR.

## Operation
- States: IDLE, FETCH, DECODE, FETCH_IMM, ISSUE, EXEC, PAUSE, HALT, ERR.
- Reset values: state IDLE, pc 0, instr_count 0, din 0, run 0, mem_addr 0, err 0, halted 0, busy 0.
- **Start.** From IDLE, HALT or ERR, `start` clears pc and instr_count and latches `prog_len`.
  - If `prog_len` == 0, go to HALT; otherwise go to FETCH.
- **FETCH.** Drive `mem_addr` = pc; go to DECODE.
- **DECODE.** Capture `mem_data` into the instruction register.
  - If opcode [8:6] == 001 (mvi): if pc+1 ≥ `prog_len`, go to ERR (truncated immediate); else drive `mem_addr` = pc+1 and go to FETCH_IMM.
  - Any other opcode: go to ISSUE.
- **FETCH_IMM.** Capture `mem_data` into the immediate register; go to ISSUE.
- **ISSUE.** Drive `din` = instruction and `run` = 1 for exactly one cycle (processor t0); go to EXEC.
- **EXEC.**
  - `run` = 0.
  - `din` = immediate for mvi, 0 otherwise; held for all EXEC cycles.
  - On `done`: pc += 2 for mvi, else pc += 1; instr_count += 1 (saturating); then pick the next state.
- **Next state after `done`**, in priority order:
  1. `stop` → IDLE.
  2. New pc ≥ `prog_len` → HALT.
  3. `step_mode` → PAUSE.
  4. Otherwise → FETCH.
- **PAUSE.** `step` → FETCH; `stop` → IDLE; if both, `stop` wins.
- **Watchdog.** A counter clears on entering EXEC. If it reaches `WD_LIMIT` without `done`, go to ERR. ERR is sticky until `start` or reset.
- **Stop timing.** `stop` in FETCH, DECODE or FETCH_IMM aborts before issue and goes to IDLE; pc is unchanged. `stop` in ISSUE or EXEC takes effect only after `done`.
- **Simultaneous events.**
  - `start` outside IDLE/HALT/ERR is ignored.
  - `done` seen on the same edge the watchdog expires counts as `done`, not an error.
- **Width rules.** pc arithmetic is ADDR_W+1 bits wide for the comparison against `prog_len`, so there is no silent wrap.
- **Reset mid-operation.** Everything returns to reset values immediately. `run` drops asynchronously.

## Timing
- All outputs are registered except `mem_addr`, which is decoded from state and pc.
- Cycles per instruction:
  - mv: 4 (FETCH, DECODE, ISSUE, EXEC).
  - mvi: 5 (adds FETCH_IMM).
  - add/sub: 6 (EXEC lasts 3 cycles, matching processor t1–t3).
- `done` is sampled on the rising edge at the end of each EXEC cycle.
- `busy` rises in the first cycle after `start` and falls in the cycle HALT, IDLE or ERR is entered.

## Structure
- A shared package holds:
  - opcode constants MV=000, MVI=001, ADD=010, SUB=011;
  - the state enum;
  - an `is_two_word(opcode)` function.
- The processor control unit uses the same opcode constants from this package.
- Single module. The watchdog is an inline counter, not a sub-module.

## Test plan
- **mvi + mv.** ROM {040, 005, 008}, `prog_len` = 3, `start`:
  - `din` = 040 with `run` high, then `din` = 005;
  - then `din` = 008 with `run` high;
  - then HALT with pc = 3, instr_count = 2, total 9 cycles.
- **add.** ROM {081}, model returns `done` in the 3rd EXEC cycle → 6 cycles, pc = 1, HALT, no `err`.
- **Watchdog.** `done` held low → ERR after 4 EXEC cycles, `run` low; `start` restarts from pc 0.
- **Step mode.** `step_mode` = 1 with 3 mv instructions → PAUSE after each; each `step` pulse advances exactly one; `stop` while in PAUSE → IDLE.
- **Truncated mvi.** mvi as last word (`prog_len` = 1, ROM {040}) → ERR from DECODE, `run` never asserted.
- **Reset mid-run.** `rst` low during EXEC of an add → all outputs return to reset values immediately; no `start` → stays in IDLE.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the 9-bit processor: opcodes, sequencer states and
// the two-word instruction test used by both sequencer and control unit.
package program_sequencer_pkg;

  localparam logic [2:0] MV  = 3'b000;
  localparam logic [2:0] MVI = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_ISSUE,
    S_EXEC,
    S_PAUSE,
    S_HALT,
    S_ERR
  } state_e;

  function automatic logic is_two_word(input logic [2:0] opcode);
    return opcode == MVI;
  endfunction

endpackage

// File: rtl/program_sequencer.sv
// Walks a synchronous instruction ROM and hands each word to the processor
// via din/run, waiting on done; mvi pulls its immediate from the next word.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 9,
  parameter int WD_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step_mode,
  input  logic              step,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_count,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  localparam int PW   = ADDR_W + 1;
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [PW-1:0]   PC_ONE  = PW'(1);
  localparam logic [PW-1:0]   PC_TWO  = PW'(2);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d, len_q, len_d;
  logic [PW-1:0]     pc_p1, pc_next;
  logic [DATA_W-1:0] ir_q, ir_d, imm_q, imm_d, din_q, din_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              run_q, run_d;
  logic              busy_q, halted_q, err_q;
  logic              ir_two;

  // pc is carried one bit wider than the ROM address so the end-of-program
  // compare against prog_len never wraps.
  assign pc_p1    = pc_q + PC_ONE;
  assign ir_two   = is_two_word(ir_q[DATA_W-1 -: 3]);
  assign pc_next  = pc_q + (ir_two ? PC_TWO : PC_ONE);
  assign mem_addr = (state_q == S_DECODE) ? pc_p1[ADDR_W-1:0] : pc_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          len_d   = prog_len;
          state_d = (prog_len == '0) ? S_HALT : S_FETCH;
        end
      end
      S_FETCH: state_d = stop ? S_IDLE : S_DECODE;
      S_DECODE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          ir_d = mem_data;
          if (is_two_word(mem_data[DATA_W-1 -: 3]))
            state_d = (pc_p1 >= len_q) ? S_ERR : S_FETCH_IMM;
          else
            state_d = S_ISSUE;
        end
      end
      S_FETCH_IMM: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          imm_d   = mem_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // done on the expiring cycle still retires the instruction
        if (done) begin
          pc_d  = pc_next;
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (stop)                  state_d = S_IDLE;
          else if (pc_next >= len_q) state_d = S_HALT;
          else if (step_mode)        state_d = S_PAUSE;
          else                       state_d = S_FETCH;
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      S_PAUSE: begin
        if (stop)      state_d = S_IDLE;
        else if (step) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with it.
    run_d = (state_d == S_ISSUE);
    din_d = '0;
    if (state_d == S_ISSUE)
      din_d = ir_d;
    else if (state_d == S_EXEC && is_two_word(ir_d[DATA_W-1 -: 3]))
      din_d = imm_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      ir_q     <= '0;
      imm_q    <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= !(state_d inside {S_IDLE, S_HALT, S_ERR});
      halted_q <= (state_d == S_HALT);
      err_q    <= (state_d == S_ERR);
    end
  end

  assign din         = din_q;
  assign run         = run_q;
  assign pc          = pc_q[ADDR_W-1:0];
  assign instr_count = cnt_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench: ROM and a small processor-done model around the sequencer,
// with hand-timed checks of din/run/pc/state flags.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  localparam int AW = 5;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, stop = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] din;
  logic          run, done;
  logic [AW-1:0] pc;
  logic [7:0]    instr_count;
  logic          busy, halted, err;

  logic [DW-1:0] rom [0:31];
  logic          kill = 1'b0;
  logic [3:0]    pcnt, need;
  int            run_cnt = 0;
  int            n_chk = 0, n_err = 0;
  int            rc;

  program_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WD_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode),
    .step(step), .prog_len(prog_len), .mem_addr(mem_addr), .mem_data(mem_data),
    .din(din), .run(run), .done(done), .pc(pc), .instr_count(instr_count),
    .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[mem_addr];

  // Processor model: done on t1 for mv/mvi, on t3 for add/sub.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      need <= 4'd1;
    end else if (run) begin
      pcnt <= 4'd1;
      need <= (din[8:6] == ADD || din[8:6] == SUB) ? 4'd3 : 4'd1;
    end else if (done) begin
      pcnt <= '0;
    end else if (pcnt != 0 && pcnt < need) begin
      pcnt <= pcnt + 4'd1;
    end
  end
  assign done = !kill && pcnt != 0 && pcnt == need;

  always @(posedge clk) if (run) run_cnt <= run_cnt + 1;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task go(input logic [AW:0] len);
    prog_len = len;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = '0;
    tick(2);
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_din", din, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b1;
    tick(1);

    // empty program halts at once
    go(0);
    chk("len0_halted", halted, 1);
    chk("len0_busy", busy, 0);

    // mvi + mv
    rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h008;
    go(3);
    chk("t1_busy", busy, 1);
    chk("t1_addr", mem_addr, 0);
    chk("t1_run0", run, 0);
    tick(3);
    chk("t1_issue_din", din, 9'h040);
    chk("t1_issue_run", run, 1);
    tick(1);
    chk("t1_imm_din", din, 9'h005);
    chk("t1_imm_run", run, 0);
    tick(3);
    chk("t1_mv_din", din, 9'h008);
    chk("t1_mv_run", run, 1);
    tick(1);
    chk("t1_exec_halted", halted, 0);
    chk("t1_exec_din", din, 0);
    tick(1);
    chk("t1_halted", halted, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_pc", pc, 3);
    chk("t1_cnt", instr_count, 2);

    // add, done in third EXEC cycle
    rom[0] = 9'h081;
    go(1);
    tick(2);
    chk("add_run", run, 1);
    chk("add_din", din, 9'h081);
    tick(3);
    chk("add_exec3_busy", busy, 1);
    chk("add_exec3_halted", halted, 0);
    tick(1);
    chk("add_halted", halted, 1);
    chk("add_pc", pc, 1);
    chk("add_err", err, 0);
    chk("add_cnt", instr_count, 1);

    // watchdog on second instruction
    rom[0] = 9'h000; rom[1] = 9'h000;
    go(2);
    tick(4);
    chk("wd_pc1", pc, 1);
    kill = 1'b1;
    tick(6);
    chk("wd_exec4_err", err, 0);
    chk("wd_exec4_busy", busy, 1);
    tick(1);
    chk("wd_err", err, 1);
    chk("wd_run", run, 0);
    chk("wd_busy", busy, 0);
    chk("wd_pc", pc, 1);
    chk("wd_cnt", instr_count, 1);
    kill = 1'b0;
    go(2);
    chk("wd_restart_pc", pc, 0);
    chk("wd_restart_cnt", instr_count, 0);
    chk("wd_restart_err", err, 0);
    chk("wd_restart_busy", busy, 1);
    tick(8);
    chk("wd_rerun_halted", halted, 1);
    chk("wd_rerun_pc", pc, 2);
    chk("wd_rerun_cnt", instr_count, 2);

    // step mode
    rom[0] = 9'h000; rom[1] = 9'h008; rom[2] = 9'h010;
    step_mode = 1'b1;
    go(3);
    tick(4);
    chk("step_p1_pc", pc, 1);
    chk("step_p1_cnt", instr_count, 1);
    chk("step_p1_busy", busy, 1);
    chk("step_p1_halted", halted, 0);
    tick(2);
    chk("step_hold_pc", pc, 1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(3);
    chk("step_mid_pc", pc, 1);
    tick(1);
    chk("step_p2_pc", pc, 2);
    chk("step_p2_cnt", instr_count, 2);
    tick(2);
    chk("step_hold2_pc", pc, 2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    step_mode = 1'b0;
    chk("step_stop_busy", busy, 0);
    chk("step_stop_halted", halted, 0);
    chk("step_stop_pc", pc, 2);

    // truncated mvi
    rom[0] = 9'h040;
    rc = run_cnt;
    go(1);
    tick(2);
    chk("trunc_err", err, 1);
    chk("trunc_busy", busy, 0);
    chk("trunc_no_run", run_cnt, rc);

    // reset during EXEC of an add
    rom[0] = 9'h000; rom[1] = 9'h081;
    go(2);
    tick(6);
    chk("mid_issue_run", run, 1);
    tick(1);
    chk("mid_exec_busy", busy, 1);
    chk("mid_exec_pc", pc, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_run", run, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_cnt", instr_count, 0);
    chk("mid_rst_din", din, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_halted", halted, 0);
    #2 rst = 1'b1;
    tick(3);
    chk("mid_idle_busy", busy, 0);
    chk("mid_idle_run", run_cnt, rc + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
